// File: rtl/score_display_pkg.sv
// Shared constants for the score display: game-state codes, segment patterns
// and the BCD-to-seven-segment table (active-low, ordered {g,f,e,d,c,b,a}).
// Pure declarations; no logic, no latency, no backpressure.
package score_display_pkg;

  localparam logic [1:0] ST_DEAD  = 2'd0;
  localparam logic [1:0] ST_GRACE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Digits 0-9, then a dash for the six non-BCD codes.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 always shows so a zero score still reads "0".
  function automatic logic digit_blank(input logic [15:0] v, input logic [1:0] k);
    return (k != 2'd0) && ((v >> {k, 2'b00}) == 16'd0);
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Bundle between the game-state logic and the display driver.
// Plain wires; latency is defined by the driver, no backpressure.
// master = score producer side, slave = display driver side.
interface score_display_if;

  logic [15:0] i_nums;
  logic [1:0]  i_state;
  logic        i_hi_clr;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame_tick;

  modport master (
    output i_nums, i_state, i_hi_clr,
    input  o_an, o_seg, o_dp, o_frame_tick
  );

  modport slave (
    input  i_nums, i_state, i_hi_clr,
    output o_an, o_seg, o_dp, o_frame_tick
  );

endinterface

// File: rtl/score_display_bcd_to_seg7.sv
// One BCD digit to active-low seven-segment pattern; codes 10-15 give a dash.
// Purely combinational, zero latency.
// No backpressure.
module bcd_to_seg7
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = SEG_TAB[bcd];

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment driver with leading-zero blanking,
// dead-state blinking and an optional high-score latch (SCORE_DISP_HISCORE_EN).
// Outputs registered, one cycle after scan/blink state; no backpressure.
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  score_display_if.slave   bus
);

  localparam int RC_W = $clog2(REFRESH_DIV > 1 ? REFRESH_DIV : 2);
  localparam int BC_W = $clog2(BLINK_DIV > 1 ? BLINK_DIV : 2);

  logic [RC_W-1:0] rc;
  logic [1:0]      idx;
  logic [15:0]     snap;
  logic [BC_W-1:0] bc;
  logic            vis;

  logic            rc_tc;
  logic            bc_tc;
  logic            frame_wrap;
  logic [15:0]     src;
  logic [3:0]      cur_digit;
  logic [6:0]      dig_seg;
  logic            blanked;
  logic            show;
  logic [3:0]      an_nxt;
  logic [6:0]      seg_nxt;

  assign rc_tc      = (rc == RC_W'(REFRESH_DIV - 1));
  assign bc_tc      = (bc == BC_W'(BLINK_DIV - 1));
  assign frame_wrap = rc_tc && (idx == 2'd3);

`ifdef SCORE_DISP_HISCORE_EN
  logic [15:0] hi;
  logic [1:0]  prev_state;

  // Remember last cycle's game state to find the entry into the dead state.
  always_ff @(posedge clk) begin
    if (rst) prev_state <= ST_DEAD;
    else     prev_state <= bus.i_state;
  end

  // High score survives reset; clear beats a same-cycle update. Packed BCD
  // orders the same as binary, so a plain unsigned compare is enough.
  always_ff @(posedge clk) begin
    if (bus.i_hi_clr)
      hi <= '0;
    else if (!rst && bus.i_state == ST_DEAD && prev_state != ST_DEAD && bus.i_nums > hi)
      hi <= bus.i_nums;
  end

  assign src = (bus.i_state == ST_GRACE) ? hi : bus.i_nums;
`else
  logic unused_hi_clr;
  assign unused_hi_clr = bus.i_hi_clr;
  assign src           = bus.i_nums;
`endif

  // Slot timer, digit index and once-per-frame snapshot so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc   <= '0;
      idx  <= 2'd0;
      snap <= '0;
    end else begin
      if (rc_tc) begin
        rc  <= '0;
        idx <= idx + 2'd1;
      end else begin
        rc <= rc + 1'b1;
      end
      if (frame_wrap) snap <= src;
    end
  end

  // Blink timer: only runs while dead; leaving dead snaps back to visible.
  always_ff @(posedge clk) begin
    if (rst || bus.i_state != ST_DEAD) begin
      bc  <= '0;
      vis <= 1'b1;
    end else if (bc_tc) begin
      bc  <= '0;
      vis <= ~vis;
    end else begin
      bc <= bc + 1'b1;
    end
  end

  assign cur_digit = 4'(snap >> {idx, 2'b00});
  assign blanked   = digit_blank(snap, idx);
  // Leaving dead forces visibility in the same cycle, before the phase
  // register has caught up.
  assign show      = (bus.i_state != ST_DEAD) || vis;

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dig_seg)
  );

  // Pick pin values for the current slot: dark when blanked or blink-hidden.
  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_BLANK;
    if (show && !blanked) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = dig_seg;
    end
  end

  // Register the pins so they are glitch-free at the board.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_an         <= 4'b1111;
      bus.o_seg        <= SEG_BLANK;
      bus.o_frame_tick <= 1'b0;
    end else begin
      bus.o_an         <= an_nxt;
      bus.o_seg        <= seg_nxt;
      bus.o_frame_tick <= frame_wrap;
    end
  end

  assign bus.o_dp = 1'b1;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  localparam int RD = 4;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_display_if bus ();

  score_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: edges since reset, consecutive dead edges,
  // the frame snapshot and the high score.
  int          k = 0;
  int          d = 0;
  logic [15:0] snap_m = 16'd0;
  logic [15:0] hi_m = 16'd0;
  logic [1:0]  prev_m = 2'd0;

  typedef struct packed {
    logic [15:0] nums;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [9];

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [15:0] rand_nums();
    logic [15:0] v;
    int zeros;
    v = 16'd0;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 7) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
      else                           v[i*4 +: 4] = 4'($urandom_range(0, 9));
    end
    zeros = $urandom_range(0, 3);
    for (int i = 0; i < zeros; i++) v[(3-i)*4 +: 4] = 4'd0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: predict the registered pins from the model, advance the
  // model by the same edge, then compare.
  task automatic cyc();
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        tick_e;
    logic        vis;
    logic        r;
    logic        clr;
    logic [1:0]  st;
    logic [15:0] nums;
    logic [15:0] src;
    logic [15:0] upper;
    int          slot;
    r     = rst;
    st    = bus.i_state;
    nums  = bus.i_nums;
    clr   = bus.i_hi_clr;
    an_e  = 4'hF;
    seg_e = 7'h7F;
    tick_e = 1'b0;
    if (!r) begin
      slot  = (k / RD) % 4;
      vis   = (st != 2'd0) || (((d / BD) % 2) == 0);
      upper = snap_m >> (4 * slot);
      if (vis && !(slot != 0 && upper == 16'd0)) begin
        an_e  = ~(4'b0001 << slot);
        seg_e = seg_ref(upper[3:0]);
      end
      tick_e = ((k % (4 * RD)) == 4 * RD - 1);
    end
    src = nums;
`ifdef SCORE_DISP_HISCORE_EN
    if (st == 2'd1) src = hi_m;
`endif
    @(posedge clk);
`ifdef SCORE_DISP_HISCORE_EN
    if (clr) hi_m = 16'd0;
    else if (!r && st == 2'd0 && prev_m != 2'd0 && nums > hi_m) hi_m = nums;
`else
    if (clr) hi_m = 16'd0;
`endif
    if (r) begin
      k = 0;
      d = 0;
      snap_m = 16'd0;
      prev_m = 2'd0;
    end else begin
      if ((k % (4 * RD)) == 4 * RD - 1) snap_m = src;
      d = (st == 2'd0) ? d + 1 : 0;
      k++;
      prev_m = st;
    end
    #1;
    chk("model", 32'({bus.o_an, bus.o_seg, bus.o_dp, bus.o_frame_tick}),
        32'({an_e, seg_e, 1'b1, tick_e}));
  endtask

  task automatic wait_tick(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (bus.o_frame_tick) seen = 1'b1;
    end
  endtask

  // After the next frame tick, check all 16 cycles of the following frame.
  task automatic frame_check(input string name, input logic [27:0] exp);
    logic       seen;
    logic [6:0] es;
    logic [3:0] ea;
    int         dg;
    wait_tick(seen);
    chk({name, "_tick"}, 32'(seen), 32'(1'b1));
    for (int j = 0; j < 16; j++) begin
      cyc();
      dg = j / 4;
      es = exp[dg*7 +: 7];
      ea = (es == 7'h7F) ? 4'hF : ~(4'b0001 << dg);
      chk({name, "_seg"}, 32'(bus.o_seg), 32'(es));
      chk({name, "_an"}, 32'(bus.o_an), 32'(ea));
    end
  endtask

  initial begin
    logic seen;
    int   n;

    vecs[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h0050, {7'h7F, 7'h7F, 7'h12, 7'h40}};
    vecs[2] = '{16'h00A7, {7'h7F, 7'h7F, 7'h3F, 7'h78}};
    vecs[3] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{16'h9999, {7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[5] = '{16'h0808, {7'h7F, 7'h00, 7'h40, 7'h00}};
    vecs[6] = '{16'h1005, {7'h79, 7'h40, 7'h40, 7'h12}};
    vecs[7] = '{16'hF000, {7'h3F, 7'h40, 7'h40, 7'h40}};
    vecs[8] = '{16'h0600, {7'h7F, 7'h02, 7'h40, 7'h40}};

    // Reset: three cycles, pins dark; high score cleared alongside.
    rst = 1'b1;
    bus.i_nums = 16'h0000;
    bus.i_state = 2'd2;
    bus.i_hi_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_an", 32'(bus.o_an), 32'(4'b1111));
      chk("rst_seg", 32'(bus.o_seg), 32'(7'h7F));
      chk("rst_dp", 32'(bus.o_dp), 32'(1'b1));
      chk("rst_tick", 32'(bus.o_frame_tick), 32'(1'b0));
    end
    rst = 1'b0;
    bus.i_hi_clr = 1'b0;
    cyc();
    chk("first_an", 32'(bus.o_an), 32'(4'b1110));
    chk("first_seg", 32'(bus.o_seg), 32'(7'h40));

    // Scan, blanking and dash patterns.
    for (int v = 0; v < 9; v++) begin
      bus.i_nums = vecs[v].nums;
      frame_check($sformatf("scan%0d", v), vecs[v].segs);
    end

    // Frame tick period.
    wait_tick(seen);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      n++;
      if (bus.o_frame_tick) seen = 1'b1;
    end
    chk("frame_period", 32'(n), 32'(16));

    // Blink: visible 8, hidden 8; leaving dead mid-hidden shows next cycle.
    bus.i_nums = 16'h1234;
    wait_tick(seen);
    bus.i_state = 2'd0;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      chk("blink_vis", 32'(bus.o_an != 4'hF), 32'(e <= 8));
    end
    bus.i_state = 2'd2;
    cyc();
    chk("blink_exit", 32'(bus.o_an != 4'hF), 32'(1'b1));

    // Snapshot: mid-frame change must not appear before the next tick.
    bus.i_nums = 16'h1111;
    wait_tick(seen);
    for (int i = 0; i < 5; i++) cyc();
    bus.i_nums = 16'h2222;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (bus.o_frame_tick) seen = 1'b1;
      else chk("snap_tear", 32'(bus.o_seg == 7'h24), 32'(1'b0));
    end
    chk("snap_tick", 32'(seen), 32'(1'b1));
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("snap_new", 32'(bus.o_seg), 32'(7'h24));
    end

`ifdef SCORE_DISP_HISCORE_EN
    // High score latch across reset, no downgrade, then clear.
    bus.i_nums = 16'h0120;
    bus.i_state = 2'd2;
    for (int i = 0; i < 3; i++) cyc();
    bus.i_state = 2'd0;
    for (int i = 0; i < 3; i++) cyc();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    bus.i_state = 2'd1;
    frame_check("hi_keep", {7'h7F, 7'h79, 7'h24, 7'h40});
    bus.i_state = 2'd2;
    bus.i_nums = 16'h0090;
    for (int i = 0; i < 3; i++) cyc();
    bus.i_state = 2'd0;
    for (int i = 0; i < 3; i++) cyc();
    bus.i_state = 2'd1;
    frame_check("hi_nodown", {7'h7F, 7'h79, 7'h24, 7'h40});
    bus.i_hi_clr = 1'b1;
    cyc();
    bus.i_hi_clr = 1'b0;
    frame_check("hi_clr", {7'h7F, 7'h7F, 7'h7F, 7'h40});
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) bus.i_nums = rand_nums();
      if ($urandom_range(0, 29) == 0) bus.i_state = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 149) == 0);
      bus.i_hi_clr = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;
    bus.i_hi_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
